// File: rtl/pio_pm_pkg.sv
// Shared types and helpers for the PIO power-management drain controller.
package pio_pm_pkg;

    // Debug-visible sequencer state encoding.
    typedef enum logic [1:0] {
        PM_IDLE  = 2'd0,
        PM_DRAIN = 2'd1,
        PM_ACK   = 2'd2,
        PM_HOLD  = 2'd3
    } pm_state_t;

    // Bits needed to hold a population count of n lanes (0..n).
    function automatic int pc_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pio_pm_popcount.sv
// Combinational population count over the per-lane pulse vector.
module pio_pm_popcount
    import pio_pm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PC_W    = pc_width(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] bits,
    output logic [PC_W-1:0]    count
);

    // Sum the set lanes.
    always_comb begin
        // NOTE: every variable written here gets a value first, so no path leaves it unassigned and no latch is inferred.
        count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            count = count + PC_W'(bits[i]);
        end
    end

endmodule

// File: rtl/pio_pm_drain_ctrl.sv
// Power-state-change sequencer: tracks outstanding PIO completions, blocks new
// requests on a power-state-change interrupt, waits for the drain (or a
// timeout) and returns a single-cycle ack to the PCIe core.
module pio_pm_drain_ctrl
    import pio_pm_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 15,
    parameter int CNT_W           = 4,
    parameter int TIMEOUT_CYCLES  = 4096,
    parameter int TO_W            = 13
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_compl,
    input  logic [NUM_REQ-1:0] compl_done,
    output logic               req_allow,
    input  logic               cfg_power_state_change_interrupt,
    output logic               cfg_power_state_change_ack,
    input  logic               clr_status,
    output logic [CNT_W-1:0]   pending_cnt,
    output logic               drain_timeout,
    output logic               cnt_err,
    output logic [1:0]         pm_state
);

    localparam int PC_W  = pc_width(NUM_REQ);
    localparam int SUM_W = CNT_W + 4;
    localparam logic signed [SUM_W-1:0] MAX_EXT = SUM_W'(MAX_OUTSTANDING);
    localparam logic [TO_W-1:0]         TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [PC_W-1:0]          inc_cnt;
    logic [PC_W-1:0]          dec_cnt;
    logic signed [SUM_W-1:0]  cnt_sum;
    logic                     cnt_ovf;
    logic                     cnt_unf;
    logic [CNT_W-1:0]         cnt_next;

    pm_state_t                state;
    pm_state_t                state_next;
    logic [TO_W-1:0]          to_cnt;
    logic [TO_W-1:0]          to_cnt_next;
    logic                     to_fire;

    pio_pm_popcount #(.NUM_REQ(NUM_REQ), .PC_W(PC_W)) u_inc (
        .bits  (req_compl),
        .count (inc_cnt)
    );

    pio_pm_popcount #(.NUM_REQ(NUM_REQ), .PC_W(PC_W)) u_dec (
        .bits  (compl_done),
        .count (dec_cnt)
    );

    // Net the inc/dec pulses into the count, clamping at both ends.
    always_comb begin
        cnt_sum  = SUM_W'(pending_cnt) + SUM_W'(inc_cnt) - SUM_W'(dec_cnt);
        cnt_unf  = cnt_sum[SUM_W-1];
        cnt_ovf  = !cnt_unf && (cnt_sum > MAX_EXT);
        cnt_next = cnt_sum[CNT_W-1:0];
        if (cnt_ovf) begin
            cnt_next = CNT_W'(MAX_OUTSTANDING);
        end else if (cnt_unf) begin
            cnt_next = '0;
        end
    end

    // Next-state and drain-timer logic. The drain check looks at the
    // registered count, so the last completion is acked two cycles later.
    always_comb begin
        state_next  = state;
        to_cnt_next = to_cnt;
        to_fire     = 1'b0;
        unique case (state)
            PM_IDLE: begin
                if (cfg_power_state_change_interrupt) begin
                    state_next  = PM_DRAIN;
                    to_cnt_next = '0;
                end
            end
            PM_DRAIN: begin
                to_cnt_next = to_cnt + TO_W'(1);
                if (pending_cnt == '0) begin
                    state_next = PM_ACK;
                end else if ((TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST)) begin
                    state_next = PM_ACK;
                    to_fire    = 1'b1;
                end else if (!cfg_power_state_change_interrupt) begin
                    state_next = PM_IDLE;
                end
            end
            PM_ACK: begin
                state_next = PM_HOLD;
            end
            PM_HOLD: begin
                if (!cfg_power_state_change_interrupt) begin
                    state_next = PM_IDLE;
                end
            end
            default: begin
                state_next = PM_IDLE;
            end
        endcase
    end

    // State, counters and sticky flags; a set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state         <= PM_IDLE;
            pending_cnt   <= '0;
            to_cnt        <= '0;
            drain_timeout <= 1'b0;
            cnt_err       <= 1'b0;
        end else begin
            state       <= state_next;
            pending_cnt <= cnt_next;
            to_cnt      <= to_cnt_next;
            if (to_fire) begin
                drain_timeout <= 1'b1;
            end else if (clr_status) begin
                drain_timeout <= 1'b0;
            end
            if (cnt_ovf || cnt_unf) begin
                cnt_err <= 1'b1;
            end else if (clr_status) begin
                cnt_err <= 1'b0;
            end
        end
    end

    assign req_allow                  = (state == PM_IDLE);
    assign cfg_power_state_change_ack = (state == PM_ACK);
    assign pm_state                   = state;

endmodule

// File: tb/tb_pio_pm_drain_ctrl.sv
// Self-checking bench for pio_pm_drain_ctrl: directed vector table, hand-written
// drain/timeout/abort/reset sequences, then randomized traffic against a model.
// Two instances share stimulus: 'a' uses the default timeout, 'b' a 16-cycle one.
module tb_pio_pm_drain_ctrl;

    localparam int NR  = 4;
    localparam int MAX = 15;
    localparam int S_IDLE = 0, S_DRAIN = 1, S_ACK = 2, S_HOLD = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req, done;
    logic          irq, clr;

    logic [3:0] a_cnt, b_cnt;
    logic       a_allow, a_ack, a_to, a_err;
    logic       b_allow, b_ack, b_to, b_err;
    logic [1:0] a_state, b_state;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model, one slot per instance.
    int m_cnt[2], m_phase[2], m_wait[2];
    bit m_to[2], m_err[2];
    int m_tmo[2] = '{4096, 16};

    always #5 clk = ~clk;

    pio_pm_drain_ctrl #(.NUM_REQ(NR), .MAX_OUTSTANDING(MAX), .CNT_W(4),
                        .TIMEOUT_CYCLES(4096), .TO_W(13)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_compl(req), .compl_done(done),
        .req_allow(a_allow), .cfg_power_state_change_interrupt(irq),
        .cfg_power_state_change_ack(a_ack), .clr_status(clr),
        .pending_cnt(a_cnt), .drain_timeout(a_to), .cnt_err(a_err),
        .pm_state(a_state)
    );

    pio_pm_drain_ctrl #(.NUM_REQ(NR), .MAX_OUTSTANDING(MAX), .CNT_W(4),
                        .TIMEOUT_CYCLES(16), .TO_W(13)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_compl(req), .compl_done(done),
        .req_allow(b_allow), .cfg_power_state_change_interrupt(irq),
        .cfg_power_state_change_ack(b_ack), .clr_status(clr),
        .pending_cnt(b_cnt), .drain_timeout(b_to), .cnt_err(b_err),
        .pm_state(b_state)
    );

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] done;
        logic          irq;
        logic          clr;
        int            cnt;
        logic          allow;
        logic          ack;
        logic          err;
        int            st;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int s, ph;
        bit e, tset;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_cnt[i] = 0; m_phase[i] = S_IDLE; m_wait[i] = 0;
                m_to[i] = 0;  m_err[i] = 0;
            end else begin
                s = m_cnt[i] + $countones(req) - $countones(done);
                e = 0;
                if (s > MAX) begin s = MAX; e = 1; end
                else if (s < 0) begin s = 0; e = 1; end
                tset = 0;
                ph = m_phase[i];
                case (m_phase[i])
                    S_IDLE:  if (irq) begin ph = S_DRAIN; m_wait[i] = 0; end
                    S_DRAIN: begin
                        if (m_cnt[i] == 0) ph = S_ACK;
                        else if (m_tmo[i] != 0 && m_wait[i] + 1 == m_tmo[i]) begin
                            ph = S_ACK; tset = 1;
                        end else if (!irq) ph = S_IDLE;
                        m_wait[i]++;
                    end
                    S_ACK:   ph = S_HOLD;
                    default: if (!irq) ph = S_IDLE;
                endcase
                if (tset) m_to[i] = 1; else if (clr) m_to[i] = 0;
                if (e) m_err[i] = 1;   else if (clr) m_err[i] = 0;
                m_cnt[i]   = s;
                m_phase[i] = ph;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [NR-1:0] r, input logic [NR-1:0] d,
                         input logic i, input logic c);
        req = r; done = d; irq = i; clr = c;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cnt"},   {a_cnt, b_cnt}, 8'h00);
        check({tag, "_allow"}, {a_allow, b_allow}, 2'b11);
        check({tag, "_ack"},   {a_ack, b_ack}, 2'b00);
        check({tag, "_state"}, {a_state, b_state}, 4'h0);
        check({tag, "_flags"}, {a_to, a_err, b_to, b_err}, 4'h0);
    endtask

    vec_t vecs[$];
    int   ack_at, ack_n, allow_bad;

    initial begin
        rst_n = 1'b0;
        drive('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        tick(); tick();
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Directed vectors: inputs for one cycle, outputs seen after that edge.
        vecs = '{
            '{4'b0111, 4'b0000, 0, 0,  3, 1, 0, 0, S_IDLE},
            '{4'b0000, 4'b0010, 0, 0,  2, 1, 0, 0, S_IDLE},
            '{4'b0000, 4'b0101, 0, 0,  0, 1, 0, 0, S_IDLE},
            '{4'b0000, 4'b0000, 1, 0,  0, 0, 0, 0, S_DRAIN},
            '{4'b0000, 4'b0000, 1, 0,  0, 0, 1, 0, S_ACK},
            '{4'b0000, 4'b0000, 1, 0,  0, 0, 0, 0, S_HOLD},
            '{4'b0000, 4'b0000, 1, 0,  0, 0, 0, 0, S_HOLD},
            '{4'b0000, 4'b0000, 0, 0,  0, 1, 0, 0, S_IDLE},
            '{4'b1111, 4'b0000, 0, 0,  4, 1, 0, 0, S_IDLE},
            '{4'b1111, 4'b0000, 0, 0,  8, 1, 0, 0, S_IDLE},
            '{4'b1111, 4'b0000, 0, 0, 12, 1, 0, 0, S_IDLE},
            '{4'b1111, 4'b0000, 0, 0, 15, 1, 0, 1, S_IDLE},
            '{4'b0000, 4'b0000, 0, 1, 15, 1, 0, 0, S_IDLE},
            '{4'b1111, 4'b1111, 0, 1, 15, 1, 0, 0, S_IDLE},
            '{4'b0001, 4'b0000, 0, 1, 15, 1, 0, 1, S_IDLE},
            '{4'b0000, 4'b0000, 0, 1, 15, 1, 0, 0, S_IDLE},
            '{4'b0000, 4'b1111, 0, 0, 11, 1, 0, 0, S_IDLE},
            '{4'b0000, 4'b1111, 0, 0,  7, 1, 0, 0, S_IDLE},
            '{4'b0000, 4'b1111, 0, 0,  3, 1, 0, 0, S_IDLE},
            '{4'b0000, 4'b1111, 0, 0,  0, 1, 0, 1, S_IDLE},
            '{4'b0001, 4'b0001, 0, 0,  0, 1, 0, 1, S_IDLE},
            '{4'b0000, 4'b0000, 0, 1,  0, 1, 0, 0, S_IDLE},
            '{4'b0001, 4'b0001, 0, 0,  0, 1, 0, 0, S_IDLE}
        };
        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].done, vecs[i].irq, vecs[i].clr);
            tick();
            check($sformatf("vec%0d_cnt", i),   a_cnt,   vecs[i].cnt);
            check($sformatf("vec%0d_allow", i), a_allow, vecs[i].allow);
            check($sformatf("vec%0d_ack", i),   a_ack,   vecs[i].ack);
            check($sformatf("vec%0d_err", i),   a_err,   vecs[i].err);
            check($sformatf("vec%0d_state", i), a_state, vecs[i].st);
        end

        // Sixteen single pulses saturate at 15; sixteen dones underflow to 0.
        for (int i = 0; i < 16; i++) begin
            drive(4'b0001 << (i % NR), '0, 1'b0, 1'b0);
            tick();
        end
        check("sat_cnt", a_cnt, 15);
        check("sat_err", a_err, 1);
        drive('0, '0, 1'b0, 1'b1); tick();
        check("sat_clr_err", a_err, 0);
        for (int i = 0; i < 16; i++) begin
            drive('0, 4'b0001 << (i % NR), 1'b0, 1'b0);
            tick();
        end
        check("unf_cnt", a_cnt, 0);
        check("unf_err", a_err, 1);
        drive('0, '0, 1'b0, 1'b1); tick();

        // Drain: count 2, interrupt at T, dones at T+10 and T+20, ack at T+22.
        drive(4'b0011, '0, 1'b0, 1'b0); tick();
        check("drain_pre_cnt", a_cnt, 2);
        ack_at = -1; ack_n = 0; allow_bad = 0;
        for (int k = 0; k < 30; k++) begin
            drive('0, (k == 10 || k == 20) ? 4'b0010 : 4'b0000, 1'b1, 1'b0);
            tick();
            if (a_ack) begin ack_n++; ack_at = k + 1; end
            if (a_allow) allow_bad++;
        end
        check("drain_ack_cycle", ack_at, 22);
        check("drain_ack_count", ack_n, 1);
        check("drain_allow_low", allow_bad, 0);
        drive('0, '0, 1'b0, 1'b0); tick();
        check("drain_drop_state", a_state, S_IDLE);
        check("drain_drop_allow", a_allow, 1);

        // Timeout on the 16-cycle instance: count 1 never completes.
        drive('0, '0, 1'b0, 1'b1); tick();
        check("to_pre_flag", b_to, 0);
        drive(4'b0001, '0, 1'b0, 1'b0); tick();
        check("to_pre_cnt", b_cnt, 1);
        ack_at = -1; ack_n = 0;
        for (int k = 0; k < 25; k++) begin
            drive('0, '0, 1'b1, 1'b0);
            tick();
            if (b_ack) begin ack_n++; ack_at = k + 1; end
            if (a_ack) ack_n += 100;
        end
        check("to_ack_cycle", ack_at, 17);
        check("to_ack_count", ack_n, 1);
        check("to_flag_set", b_to, 1);
        check("to_long_flag", a_to, 0);
        drive('0, '0, 1'b0, 1'b0); tick();
        check("to_abort_state", a_state, S_IDLE);
        tick(); tick();
        check("to_flag_sticky", b_to, 1);
        drive('0, '0, 1'b0, 1'b1); tick();
        check("to_flag_clr", b_to, 0);
        drive('0, 4'b0001, 1'b0, 1'b0); tick();
        check("to_post_cnt", a_cnt, 0);

        // Abort: interrupt drops in DRAIN with count 3, no ack ever.
        drive(4'b0111, '0, 1'b0, 1'b0); tick();
        for (int k = 0; k < 5; k++) begin drive('0, '0, 1'b1, 1'b0); tick(); end
        check("abort_in_drain", a_state, S_DRAIN);
        ack_n = 0;
        for (int k = 0; k < 10; k++) begin
            drive('0, '0, 1'b0, 1'b0); tick();
            if (a_ack || b_ack) ack_n++;
        end
        check("abort_no_ack", ack_n, 0);
        check("abort_state", a_state, S_IDLE);
        check("abort_cnt", a_cnt, 3);

        // Reset mid-drain: everything back to reset values, no ack.
        for (int k = 0; k < 4; k++) begin drive('0, '0, 1'b1, 1'b0); tick(); end
        check("rst_in_drain", a_state, S_DRAIN);
        rst_n = 1'b0; drive('0, '0, 1'b0, 1'b0); tick();
        check_reset_vals("rst_mid");
        rst_n = 1'b1;
        ack_n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (a_ack || b_ack) ack_n++;
        end
        check("rst_no_ack", ack_n, 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            req   = NR'($urandom & $urandom);
            done  = NR'($urandom & $urandom);
            if ($urandom_range(0, 15) == 0) irq = ~irq;
            clr   = ($urandom_range(0, 29) == 0);
            tick();
            check("rand_a", {a_cnt, a_allow, a_ack, a_to, a_err, a_state},
                  {4'(m_cnt[0]), m_phase[0] == S_IDLE, m_phase[0] == S_ACK,
                   m_to[0], m_err[0], 2'(m_phase[0])});
            check("rand_b", {b_cnt, b_allow, b_ack, b_to, b_err, b_state},
                  {4'(m_cnt[1]), m_phase[1] == S_IDLE, m_phase[1] == S_ACK,
                   m_to[1], m_err[1], 2'(m_phase[1])});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
